apb_mem_slave: RTL and testbench

Parametrised APB3/APB4 memory slave with configurable data width, depth and wait states. Supports byte-strobed writes and flags out-of-range or misaligned accesses with Pslverr. Keeps a saturating error counter. Sits on the peripheral bus behind the APB bridge as scratch/config RAM, generalising the fixed 32x32 zero-wait memory slave.

---
 rtl/apb_mem_slave.sv | 144 ++++++++++++++
 tb/tb_apb_mem_slave.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB3/APB4 scratch/config RAM slave with configurable width, depth and wait states.
// Errored (misaligned or out-of-range) transfers complete with Pslverr and bump a saturating counter.
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                   Pclk,
  input  logic                   Prst,
  input  logic [ADDR_W-1:0]      Paddr,
  input  logic                   Pselx,
  input  logic                   Penable,
  input  logic                   Pwrite,
  input  logic [DATA_W-1:0]      Pwdata,
  input  logic [DATA_W/8-1:0]    Pstrb,
  output logic                   Pready,
  output logic                   Pslverr,
  output logic [DATA_W-1:0]      Prdata,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  // Misaligned low bits, or any word index beyond the array, is an error.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    addr_bad = ((a & LANE_MASK) != {ADDR_W{1'b0}}) || ((a >> OFF) >= DEPTH_A);
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic              r_err;
  logic [DATA_W-1:0] r_wdata;
  logic [BYTES-1:0]  r_strb;

  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic              w_setup;
  logic              w_access;
  logic              w_commit;

  assign w_idx    = Paddr[OFF +: IDX_W];
  assign w_err    = addr_bad(Paddr);
  assign w_setup  = Pselx & ~Penable;
  assign w_access = Pselx & Penable;
  assign w_commit = (r_state == S_READY) & w_access & r_write & ~r_err;

  // Transfer FSM; all bus outputs are registered and only nonzero in READY.
  always_ff @(posedge Pclk or negedge Prst) begin
    if (!Prst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= {DATA_W{1'b0}};
      r_strb  <= {BYTES{1'b0}};
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= {DATA_W{1'b0}};
      err_cnt <= {ERR_CNT_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          Pready  <= 1'b0;
          Pslverr <= 1'b0;
          Prdata  <= {DATA_W{1'b0}};
          if (w_setup) begin
            r_idx   <= w_idx;
            r_write <= Pwrite;
            r_wdata <= Pwdata;
            r_strb  <= Pstrb;
            r_err   <= w_err;
            r_cnt   <= CNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              r_state <= S_READY;
              Pready  <= 1'b1;
              Pslverr <= w_err;
              Prdata  <= (!Pwrite && !w_err) ? r_mem[w_idx] : {DATA_W{1'b0}};
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!w_access) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state <= S_READY;
            Pready  <= 1'b1;
            Pslverr <= r_err;
            Prdata  <= (!r_write && !r_err) ? r_mem[r_idx] : {DATA_W{1'b0}};
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_READY: begin
          // Completion and abort both return to IDLE; only completion counts errors.
          r_state <= S_IDLE;
          Pready  <= 1'b0;
          Pslverr <= 1'b0;
          Prdata  <= {DATA_W{1'b0}};
          if (w_access && r_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          Pready  <= 1'b0;
          Pslverr <= 1'b0;
          Prdata  <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // Storage is deliberately not reset; byte lanes commit only on a clean completion.
  always_ff @(posedge Pclk) begin
    if (w_commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (r_strb[i]) begin
          r_mem[r_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances (0, 2 and 3 wait states; one with a 2-bit error counter)
// checked every cycle against a transfer-level model, plus directed literal expectations.
module tb_apb_mem_slave;

  logic Pclk = 1'b0;
  logic Prst;
  always #5 Pclk = ~Pclk;

  logic [2:0][31:0] paddr, pwdata, prd;
  logic [2:0][3:0]  pstrb;
  logic [2:0]       psel, pen, pwr, prdy, perr;
  logic [15:0]      ecnt0, ecnt1;
  logic [1:0]       ecnt2;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_STATES(0), .ERR_CNT_W(16)) u0 (
    .Pclk(Pclk), .Prst(Prst), .Paddr(paddr[0]), .Pselx(psel[0]), .Penable(pen[0]),
    .Pwrite(pwr[0]), .Pwdata(pwdata[0]), .Pstrb(pstrb[0]), .Pready(prdy[0]),
    .Pslverr(perr[0]), .Prdata(prd[0]), .err_cnt(ecnt0));
  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_STATES(2), .ERR_CNT_W(16)) u1 (
    .Pclk(Pclk), .Prst(Prst), .Paddr(paddr[1]), .Pselx(psel[1]), .Penable(pen[1]),
    .Pwrite(pwr[1]), .Pwdata(pwdata[1]), .Pstrb(pstrb[1]), .Pready(prdy[1]),
    .Pslverr(perr[1]), .Prdata(prd[1]), .err_cnt(ecnt1));
  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_STATES(3), .ERR_CNT_W(2)) u2 (
    .Pclk(Pclk), .Prst(Prst), .Paddr(paddr[2]), .Pselx(psel[2]), .Penable(pen[2]),
    .Pwrite(pwr[2]), .Pwdata(pwdata[2]), .Pstrb(pstrb[2]), .Pready(prdy[2]),
    .Pslverr(perr[2]), .Prdata(prd[2]), .err_cnt(ecnt2));

  // Transfer-level model state and the per-cycle expectations derived from it
  logic [31:0]      mem_m [3][32];
  int               ecnt_m [3];
  logic [2:0]       exp_rdy, exp_err;
  logic [2:0][31:0] exp_rd;
  logic [31:0]      last_rd [3];
  logic             last_err [3];
  logic             last_rdy [3];
  bit               chk_on = 1'b0;
  int               n_tests = 0;
  int               n_fail = 0;

  function automatic int ws(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic int ecnt_max(input int d);
    return (d == 2) ? 3 : 65535;
  endfunction

  function automatic logic [31:0] ecnt_of(input int d);
    return (d == 0) ? 32'(ecnt0) : ((d == 1) ? 32'(ecnt1) : 32'(ecnt2));
  endfunction

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge Pclk);
    #1;
  endtask

  task automatic clear_exp(input int d);
    exp_rdy[d] = 1'b0;
    exp_err[d] = 1'b0;
    exp_rd[d]  = 32'h0;
  endtask

  // One APB transfer, timed from the protocol rules, updating the model at completion.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] sb, input int abort_at, input bit rst_ready);
    bit err;
    int idx;
    err = (a % 32'd4 != 32'd0) || (a / 32'd4 >= 32'd32);
    idx = int'((a / 32'd4) % 32'd32);
    psel[d] = 1'b1; pen[d] = 1'b0; pwr[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = sb;
    clear_exp(d);
    cyc();
    pen[d] = 1'b1;
    for (int j = 0; j < ws(d); j++) begin
      if (j == abort_at) begin
        psel[d] = 1'b0;
        pen[d]  = 1'b0;
        cyc();
        return;
      end
      cyc();
    end
    exp_rdy[d] = 1'b1;
    exp_err[d] = err;
    exp_rd[d]  = (!wr && !err) ? mem_m[d][idx] : 32'h0;
    if (rst_ready) begin
      #2;
      Prst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        clear_exp(k);
        ecnt_m[k] = 0;
        psel[k] = 1'b0;
        pen[k]  = 1'b0;
      end
      #1;
      check("rst_async_rdy", d, 32'(prdy[d]), 32'h0);
      check("rst_async_err", d, 32'(perr[d]), 32'h0);
      check("rst_async_rdata", d, prd[d], 32'h0);
      check("rst_async_ecnt", d, ecnt_of(d), 32'h0);
      cyc();
      cyc();
      Prst = 1'b1;
      return;
    end
    @(negedge Pclk);
    last_rd[d]  = prd[d];
    last_err[d] = perr[d];
    last_rdy[d] = prdy[d];
    cyc();
    if (err) begin
      if (ecnt_m[d] < ecnt_max(d)) ecnt_m[d]++;
    end else if (wr) begin
      for (int i = 0; i < 4; i++) begin
        if (sb[i]) mem_m[d][idx][i*8 +: 8] = wd[i*8 +: 8];
      end
    end
    clear_exp(d);
    psel[d] = 1'b0;
    pen[d]  = 1'b0;
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge Pclk) begin
    if (chk_on) begin
      for (int d = 0; d < 3; d++) begin
        check("pready", d, 32'(prdy[d]), 32'(exp_rdy[d]));
        check("pslverr", d, 32'(perr[d]), 32'(exp_err[d]));
        check("prdata", d, prd[d], exp_rd[d]);
        check("err_cnt", d, ecnt_of(d), 32'(ecnt_m[d]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr;
    int          d, kind, ab;
    logic [31:0] a;
    Prst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      psel[k] = 1'b0; pen[k] = 1'b0; pwr[k] = 1'b0;
      paddr[k] = 32'h0; pwdata[k] = 32'h0; pstrb[k] = 4'h0;
      clear_exp(k);
      ecnt_m[k] = 0;
    end
    chk_on = 1'b1;
    cyc();
    cyc();
    for (int k = 0; k < 3; k++) begin
      check("reset_pready", k, 32'(prdy[k]), 32'h0);
      check("reset_pslverr", k, 32'(perr[k]), 32'h0);
      check("reset_prdata", k, prd[k], 32'h0);
      check("reset_err_cnt", k, ecnt_of(k), 32'h0);
    end
    Prst = 1'b1;
    cyc();

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 32; w++)
        xfer(k, 1'b1, 32'(w * 4), $urandom, 4'hF, -1, 1'b0);

    // Basic zero-wait write then read
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, -1, 1'b0);
    check("rd_deadbeef", 0, last_rd[0], 32'hDEADBEEF);
    check("rd_ok_err", 0, 32'(last_err[0]), 32'h0);
    check("rd_ok_rdy", 0, 32'(last_rdy[0]), 32'h1);

    // Two wait states
    xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, -1, 1'b0);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, -1, 1'b0);
    check("ws2_rd", 1, last_rd[1], 32'hDEADBEEF);

    // Byte strobes
    xfer(0, 1'b1, 32'h04, 32'h11223344, 4'hF, -1, 1'b0);
    xfer(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, -1, 1'b0);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, -1, 1'b0);
    check("strb_merge", 0, last_rd[0], 32'h11BB33DD);

    // Error transfers
    xfer(0, 1'b1, 32'h80, 32'h55555555, 4'hF, -1, 1'b0);
    check("oor_wr_err", 0, 32'(last_err[0]), 32'h1);
    xfer(0, 1'b0, 32'h82, 32'h0, 4'h0, -1, 1'b0);
    check("mis_rd_err", 0, 32'(last_err[0]), 32'h1);
    check("mis_rd_data", 0, last_rd[0], 32'h0);
    check("err_cnt_two", 0, ecnt_of(0), 32'd2);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, -1, 1'b0);
    check("oor_no_alias", 0, last_rd[0], 32'hDEADBEEF);

    // Abort during wait states
    xfer(2, 1'b1, 32'h20, 32'h12345678, 4'hF, -1, 1'b0);
    xfer(2, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1, 1'b0);
    xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, -1, 1'b0);
    check("abort_unchanged", 2, last_rd[2], 32'h12345678);
    check("abort_ecnt", 2, ecnt_of(2), 32'h0);

    // Counter saturation at 2 bits
    for (int k = 0; k < 5; k++) xfer(2, k[0], 32'h81 + 32'(k), 32'h0, 4'hF, -1, 1'b0);
    check("ecnt_sat", 2, ecnt_of(2), 32'd3);

    // Reset during READY discards the write
    xfer(1, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, -1, 1'b0);
    xfer(1, 1'b1, 32'h14, 32'h0BADBEEF, 4'hF, -1, 1'b1);
    xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, -1, 1'b0);
    check("rst_no_commit", 1, last_rd[1], 32'hCAFEF00D);
    check("rst_ecnt2", 2, ecnt_of(2), 32'h0);

    // Randomised back-to-back traffic with occasional errors, aborts and idles
    for (int n = 0; n < 300; n++) begin
      d    = $urandom_range(0, 2);
      wr   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
      else if (kind == 1) a = $urandom | 32'h0000_0080;
      else                a = 32'($urandom_range(0, 31) * 4);
      ab = (ws(d) > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, ws(d) - 1) : -1;
      xfer(d, wr, a, $urandom, 4'($urandom), ab, 1'b0);
      if ($urandom_range(0, 3) == 0) cyc();
    end

    cyc();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
